// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end: pc_src encodings,
// fetch-queue entry layout and a sizing helper.
package if_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_JUMP   = 2'b01,
    PCSRC_BRANCH = 2'b10,
    PCSRC_RETURN = 2'b11
  } pc_src_e;

  localparam int IF_ADDR_W  = 16;
  localparam int IF_INSTR_W = 16;

  // Queue payload at the default widths; the queue itself is width-generic.
  typedef struct packed {
    logic [IF_INSTR_W-1:0] instr;
    logic [IF_ADDR_W-1:0]  pc;
  } fq_entry_t;

  function automatic int fq_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Small synchronous FIFO with flush and a combinational head read.
// Flush has priority over push and pop; storage is zeroed on reset.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic [DATA_W-1:0]       head_data,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fq_count_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);

  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push, do_pop;
  logic [DEPTH-1:0][DATA_W-1:0] entry_q;

  assign empty   = (count_reg == '0);
  assign do_push = push & ~flush & (count_reg != FULL_C);
  assign do_pop  = pop & ~flush & ~empty;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (!rst_n)
        data_reg <= '0;
      else if (do_push && wr_ptr_reg == AW'(gi))
        data_reg <= push_data;
    end
    assign entry_q[gi] = data_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + ONE_P;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + ONE_P;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + ONE_C;
        2'b01:   count_reg <= count_reg - ONE_C;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count     = count_reg;
  assign head_data = entry_q[rd_ptr_reg];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one in-flight synchronous memory read, a
// credit-checked fetch queue and redirect flush. Optional RAS: IF_RAS_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int INSTR_W   = 16,
  parameter int RESET_PC  = 0,
  parameter int PC_STEP   = 2,
  parameter int FQ_DEPTH  = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 pc_src,
  input  logic [ADDR_W-1:0]          j_target,
  input  logic [ADDR_W-1:0]          i_target,
  input  logic [ADDR_W-1:0]          return_addr,
`ifdef IF_RAS_EN
  input  logic                       ras_push,
  input  logic [ADDR_W-1:0]          ras_push_addr,
`endif
  output logic                       imem_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_npc,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  localparam int CW = fq_count_w(FQ_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [CW-1:0]     DEPTH_C = CW'(FQ_DEPTH);

  pc_src_e                   src;
  logic                      redirect, issue, fq_push, fq_pop, fq_empty;
  logic                      inflight_reg;
  logic [ADDR_W-1:0]         pc_reg, pc_next, inflight_pc_reg, target, ret_target;
  logic [CW-1:0]             fq_count_raw, credits_used;
  logic [INSTR_W+ADDR_W-1:0] head_data;
  logic [ADDR_W-1:0]         head_pc;

  assign src      = pc_src_e'(pc_src);
  assign redirect = (src != PCSRC_SEQ);

  // Credits count the queued entries plus the read still in flight; a pop
  // in the same cycle is deliberately not credited.
  assign credits_used = fq_count_raw + CW'(inflight_reg);
  assign issue        = rst_n & ~redirect & (credits_used < DEPTH_C);
  assign fq_push      = inflight_reg & ~redirect;
  assign fq_pop       = out_valid & out_ready;

`ifdef IF_RAS_EN
  localparam int RAW = $clog2(RAS_DEPTH);
  localparam logic [RAW:0]   RAS_FULL = (RAW+1)'(RAS_DEPTH);
  localparam logic [RAW:0]   RAS_ONE  = (RAW+1)'(1);
  localparam logic [RAW-1:0] PTR_ONE  = RAW'(1);

  logic [RAW-1:0]                 ras_top_reg, ras_wr_idx;
  logic [RAW:0]                   ras_count_reg;
  logic [RAS_DEPTH-1:0][ADDR_W-1:0] ras_entry;
  logic                           ras_hit, ras_pop;

  assign ras_hit    = (ras_count_reg != '0);
  assign ras_pop    = (src == PCSRC_RETURN) && ras_hit;
  // A simultaneous pop frees the top slot, so the push lands there.
  assign ras_wr_idx = ras_pop ? ras_top_reg : ras_top_reg + PTR_ONE;
  assign ret_target = ras_hit ? ras_entry[ras_top_reg] : return_addr;

  genvar gi;
  for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
    logic [ADDR_W-1:0] addr_reg;
    always_ff @(posedge clk) begin
      if (!rst_n)
        addr_reg <= '0;
      else if (ras_push && ras_wr_idx == RAW'(gi))
        addr_reg <= ras_push_addr;
    end
    assign ras_entry[gi] = addr_reg;
  end

  // Circular stack: a push when full advances over the oldest slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_top_reg   <= '0;
      ras_count_reg <= '0;
    end else begin
      case ({ras_push, ras_pop})
        2'b10: begin
          ras_top_reg <= ras_top_reg + PTR_ONE;
          if (ras_count_reg != RAS_FULL) ras_count_reg <= ras_count_reg + RAS_ONE;
        end
        2'b01: begin
          ras_top_reg   <= ras_top_reg - PTR_ONE;
          ras_count_reg <= ras_count_reg - RAS_ONE;
        end
        default: begin
          ras_top_reg   <= ras_top_reg;
          ras_count_reg <= ras_count_reg;
        end
      endcase
    end
  end
`else
  assign ret_target = return_addr;
`endif

  always_comb begin
    target = pc_reg;
    case (src)
      PCSRC_JUMP:   target = j_target;
      PCSRC_BRANCH: target = i_target;
      PCSRC_RETURN: target = ret_target;
      default:      target = pc_reg;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect)
      pc_next = target;
    else if (issue)
      pc_next = pc_reg + STEP_A;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg          <= RST_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= pc_reg;
    end
  end

  if_fetch_queue #(
    .DATA_W (INSTR_W + ADDR_W),
    .DEPTH  (FQ_DEPTH)
  ) u_fq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fq_push),
    .push_data ({imem_rdata, inflight_pc_reg}),
    .pop       (fq_pop),
    .flush     (redirect),
    .count     (fq_count_raw),
    .head_data (head_data),
    .empty     (fq_empty)
  );

  assign head_pc   = head_data[ADDR_W-1:0];
  assign imem_en   = issue;
  assign imem_addr = rst_n ? pc_reg : RST_PC;
  assign pc        = rst_n ? pc_reg : RST_PC;
  assign out_valid = rst_n & ~fq_empty;
  assign out_instr = rst_n ? head_data[INSTR_W+ADDR_W-1:ADDR_W] : '0;
  assign out_pc    = rst_n ? head_pc : '0;
  assign out_npc   = rst_n ? head_pc + STEP_A : '0;
  assign fq_count  = rst_n ? fq_count_raw : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: expected fetch stream queued on reset/redirect,
// popped and compared whenever decode accepts an instruction.
module tb_if_fetch_unit;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [15:0] j_target = '0, i_target = '0, return_addr = '0;
`ifdef IF_RAS_EN
  logic        ras_push = 1'b0;
  logic [15:0] ras_push_addr = '0;
`endif
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr, out_pc, out_npc, pc;
  logic [2:0]  fq_count;

  int n_cmp = 0;
  int n_err = 0;
  fq_entry_t exp_q[$];

  if_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_src      (pc_src),
    .j_target    (j_target),
    .i_target    (i_target),
    .return_addr (return_addr),
`ifdef IF_RAS_EN
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
`endif
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_npc     (out_npc),
    .pc          (pc),
    .fq_count    (fq_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word at A is A ^ 16'hA5A5.
  always @(posedge clk) if (imem_en) imem_rdata <= imem_addr ^ 16'hA5A5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_restart(input logic [15:0] start);
    fq_entry_t   e;
    logic [15:0] a;
    a = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc    = a;
      e.instr = a ^ 16'hA5A5;
      exp_q.push_back(e);
      a = a + 16'd2;
    end
  endtask

  task automatic at_neg();
    fq_entry_t   e;
    logic [15:0] npc_exp;
    @(negedge clk);
    if (rst_n && pc_src == 2'b00 && out_valid && out_ready) begin
      check("sb_expect_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        npc_exp = e.pc + 16'd2;
        check("out_pc", 32'(out_pc), 32'(e.pc));
        check("out_instr", 32'(out_instr), 32'(e.instr));
        check("out_npc", 32'(out_npc), 32'(npc_exp));
        $display("deliver pc=%04h instr=%04h npc=%04h", out_pc, out_instr, out_npc);
      end
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      at_neg();
      to_next();
    end
  endtask

  task automatic do_redirect(input logic [1:0] src, input logic [15:0] tgt_in,
                             input logic [15:0] exp_tgt);
    pc_src = src;
    case (src)
      2'b01:   j_target    = tgt_in;
      2'b10:   i_target    = tgt_in;
      default: return_addr = tgt_in;
    endcase
    out_ready = 1'b1;
    sb_restart(exp_tgt);
    at_neg();
    check("redir_no_issue", 32'(imem_en), 32'd0);
    to_next();
    pc_src = 2'b00;
    check("redir_pc", 32'(pc), 32'(exp_tgt));
    check("redir_flush_count", 32'(fq_count), 32'd0);
    at_neg(); check("redir_t1_valid", 32'(out_valid), 32'd0); to_next();
    at_neg(); check("redir_t2_valid", 32'(out_valid), 32'd0); to_next();
    at_neg();
    check("redir_t3_valid", 32'(out_valid), 32'd1);
    check("redir_t3_pc", 32'(out_pc), 32'(exp_tgt));
    to_next();
  endtask

`ifdef IF_RAS_EN
  task automatic push_ras(input logic [15:0] addr);
    ras_push      = 1'b1;
    ras_push_addr = addr;
    run(1);
    ras_push      = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs held at their reset values while rst_n is low
    #1;
    check("rst_imem_en", 32'(imem_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fq_count", 32'(fq_count), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    to_next();
    to_next();
    check("rst_pc", 32'(pc), 32'd0);

    // Release: first instruction presented in cycle 2
    sb_restart(16'h0000);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    at_neg(); check("c0_imem_en", 32'(imem_en), 32'd1); check("c0_valid", 32'(out_valid), 32'd0); to_next();
    at_neg(); check("c1_valid", 32'(out_valid), 32'd0); to_next();
    at_neg(); check("c2_valid", 32'(out_valid), 32'd1); to_next();
    run(6);

    // Back-pressure: queue fills to depth, then drains without gaps
    out_ready = 1'b0;
    run(10);
    check("bp_fq_count", 32'(fq_count), 32'd4);
    check("bp_imem_en", 32'(imem_en), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check("drain_valid", 32'(out_valid), 32'd1);
      to_next();
    end

    // Jump redirect with three entries queued and a read in flight
    out_ready = 1'b0;
    for (int k = 0; k < 20 && fq_count != 3'd3; k++) run(1);
    check("pre_jump_count", 32'(fq_count), 32'd3);
    do_redirect(2'b01, 16'h0040, 16'h0040);
    run(4);

    // Address wrap through 0xFFFE -> 0x0000
    do_redirect(2'b01, 16'hFFFC, 16'hFFFC);
    run(4);

    do_redirect(2'b10, 16'h1230, 16'h1230);
    run(2);
`ifndef IF_RAS_EN
    do_redirect(2'b11, 16'h0300, 16'h0300);
    run(2);
`endif

    // Reset while the queue is full
    out_ready = 1'b0;
    run(6);
    check("full_before_rst", 32'(fq_count), 32'd4);
    rst_n = 1'b0;
    at_neg();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_imem_en", 32'(imem_en), 32'd0);
    to_next();
    rst_n = 1'b1;
    check("postrst_count", 32'(fq_count), 32'd0);
    check("postrst_valid", 32'(out_valid), 32'd0);
    check("postrst_pc", 32'(pc), 32'd0);
    sb_restart(16'h0000);
    out_ready = 1'b1;
    run(6);

`ifdef IF_RAS_EN
    push_ras(16'h0100);
    push_ras(16'h0200);
    do_redirect(2'b11, 16'h0300, 16'h0200);
    do_redirect(2'b11, 16'h0300, 16'h0100);
    do_redirect(2'b11, 16'h0300, 16'h0300);
    push_ras(16'h0010);
    push_ras(16'h0020);
    push_ras(16'h0030);
    push_ras(16'h0040);
    push_ras(16'h0050);
    do_redirect(2'b11, 16'h0300, 16'h0050);
    do_redirect(2'b11, 16'h0300, 16'h0040);
    do_redirect(2'b11, 16'h0300, 16'h0030);
    do_redirect(2'b11, 16'h0300, 16'h0020);
    do_redirect(2'b11, 16'h0300, 16'h0300);
    run(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
